// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//   Serial pattern detector built as a Moore FSM over "bits of PATTERN matched
//   so far". Mismatches fall back along a KMP failure table that is computed
//   from PATTERN at elaboration, so overlapping occurrences are never missed.
//   PATTERN[PATTERN_W-1] is the first bit expected on the line.
//
//   Parameters
//     PATTERN_W  pattern length in bits (2..16)
//     PATTERN    target sequence, MSB received first
//     STICKY     1: latch start_shifting after the first match until
//                   reset/restart; 0: one-cycle pulse per match
//     CNT_W      width of the saturating match counter
//
//   Ports
//     clk             sole clock, rising edge
//     reset           synchronous active-high reset (highest priority)
//     data            serial input bit
//     valid           qualifies data; nothing advances when low
//     restart         synchronous re-arm: clears progress and the sticky flag,
//                     keeps match_count
//     start_shifting  registered match indication
//     progress        registered number of pattern bits currently matched
//                     (reads PATTERN_W while latched in sticky mode)
//     match_count     registered saturating number of matches since reset
// -----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
    parameter bit                   STICKY    = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             data,
    input  logic                             valid,
    input  logic                             restart,
    output logic                             start_shifting,
    output logic [$clog2(PATTERN_W+1)-1:0]   progress,
    output logic [CNT_W-1:0]                 match_count
);

    localparam int PW    = $clog2(PATTERN_W + 1);
    // Table depth rounded up to a power of two so the progress register can
    // index it directly; entries beyond PATTERN_W-1 are never reached.
    localparam int TBL_N = 2 ** PW;

    // Longest proper prefix of PATTERN (length < PATTERN_W) that is a suffix of
    // "first p pattern bits followed by b". When b completes the pattern this
    // yields the failure value of the whole pattern, which is exactly where
    // pulse mode must resume to catch overlapping matches.
    function automatic int kmp_next(input int p, input bit b);
        int best;
        int idx;
        bit ok;
        bit sb;
        best = 0;
        for (int k = 1; k < PATTERN_W; k++) begin
            if (k <= p + 1) begin
                ok = 1'b1;
                for (int j = 0; j < PATTERN_W; j++) begin
                    if (j < k) begin
                        idx = p + 1 - k + j;
                        sb  = (idx == p) ? b : PATTERN[PATTERN_W-1-idx];
                        if (sb != PATTERN[PATTERN_W-1-j]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_DONE   = 1'b1
    } state_t;

    logic [PW-1:0] w_next0 [TBL_N];
    logic [PW-1:0] w_next1 [TBL_N];
    logic [PW-1:0] w_next;
    logic          w_match;

    genvar gi;
    generate
        for (gi = 0; gi < TBL_N; gi++) begin : g_tbl
            if (gi < PATTERN_W) begin : g_live
                assign w_next0[gi] = PW'(kmp_next(gi, 1'b0));
                assign w_next1[gi] = PW'(kmp_next(gi, 1'b1));
            end else begin : g_pad
                assign w_next0[gi] = '0;
                assign w_next1[gi] = '0;
            end
        end
    endgenerate

    state_t           r_state;
    logic [PW-1:0]    r_p;
    logic             r_start;
    logic [CNT_W-1:0] r_cnt;

    assign w_next  = data ? w_next1[r_p] : w_next0[r_p];
    // The last bit received is PATTERN[0]; matching it from the final
    // progress value completes the pattern.
    assign w_match = (r_p == PW'(PATTERN_W - 1)) && (data == PATTERN[0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_SEARCH;
            r_p     <= '0;
            r_start <= 1'b0;
            r_cnt   <= '0;
        end else if (restart) begin
            r_state <= S_SEARCH;
            r_p     <= '0;
            r_start <= 1'b0;
        end else begin
            case (r_state)
                S_SEARCH: begin
                    if (valid) begin
                        if (w_match) begin
                            r_start <= 1'b1;
                            if (r_cnt != {CNT_W{1'b1}}) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                            if (STICKY) begin
                                r_state <= S_DONE;
                                r_p     <= PW'(PATTERN_W);
                            end else begin
                                r_p <= w_next;
                            end
                        end else begin
                            r_start <= 1'b0;
                            r_p     <= w_next;
                        end
                    end else if (!STICKY) begin
                        r_start <= 1'b0;
                    end
                end
                S_DONE: begin
                    // Latched: input stream ignored until reset or restart.
                    r_start <= 1'b1;
                    r_p     <= PW'(PATTERN_W);
                end
                default: begin
                    r_state <= S_SEARCH;
                    r_p     <= '0;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    assign start_shifting = r_start;
    assign progress       = r_p;
    assign match_count    = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
//   Drives one stimulus stream into two detectors (sticky/8-bit counter and
//   pulse/2-bit counter). A reference model based on the full accepted-bit
//   history predicts every cycle's outputs; predictions go into a queue per
//   instance and are popped and compared once the DUT has registered them.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

    localparam int         W   = 4;
    localparam logic [3:0] PAT = 4'b1101;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       data    = 1'b0;
    logic       valid   = 1'b0;
    logic       restart = 1'b0;

    logic       s_start;
    logic [2:0] s_prog;
    logic [7:0] s_cnt;
    logic       p_start;
    logic [2:0] p_prog;
    logic [1:0] p_cnt;

    seq_detect_param #(
        .PATTERN_W(4), .PATTERN(4'b1101), .STICKY(1'b1), .CNT_W(8)
    ) u_dut_s (
        .clk(clk), .reset(reset), .data(data), .valid(valid), .restart(restart),
        .start_shifting(s_start), .progress(s_prog), .match_count(s_cnt)
    );

    seq_detect_param #(
        .PATTERN_W(4), .PATTERN(4'b1101), .STICKY(1'b0), .CNT_W(2)
    ) u_dut_p (
        .clk(clk), .reset(reset), .data(data), .valid(valid), .restart(restart),
        .start_shifting(p_start), .progress(p_prog), .match_count(p_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int p;
        int st;
        int cnt;
    } exp_t;

    exp_t q_s[$];
    exp_t q_p[$];

    // Model state, index 0 = sticky instance, 1 = pulse instance
    int          m_p    [2];
    int          m_st   [2];
    int          m_cnt  [2];
    bit          m_done [2];
    logic [31:0] m_hist [2];
    int          m_hlen [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Longest k (1..maxk) such that the last k accepted bits equal the first k
    // pattern bits. h[0] is the most recent bit.
    function automatic int lsp(input logic [31:0] h, input int len, input int maxk);
        int best;
        bit ok;
        best = 0;
        for (int k = 1; k <= maxk; k++) begin
            if (k <= len) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (h[k-1-j] != PAT[W-1-j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    task automatic model_step(input int m, input bit rs_t, input bit rr, input bit v, input bit d);
        bit sticky;
        int cmax;
        int k;
        sticky = (m == 0);
        cmax   = (m == 0) ? 255 : 3;
        if (rs_t) begin
            m_p[m] = 0; m_st[m] = 0; m_cnt[m] = 0; m_done[m] = 1'b0;
            m_hist[m] = '0; m_hlen[m] = 0;
        end else if (rr) begin
            m_p[m] = 0; m_st[m] = 0; m_done[m] = 1'b0;
            m_hist[m] = '0; m_hlen[m] = 0;
        end else if (m_done[m]) begin
            m_st[m] = 1;
        end else if (v) begin
            m_hist[m] = {m_hist[m][30:0], d};
            if (m_hlen[m] < 32) m_hlen[m]++;
            k = lsp(m_hist[m], m_hlen[m], W);
            if (k == W) begin
                m_st[m] = 1;
                if (m_cnt[m] < cmax) m_cnt[m]++;
                if (sticky) begin
                    m_done[m] = 1'b1;
                    m_p[m]    = W;
                end else begin
                    m_p[m] = lsp(m_hist[m], m_hlen[m], W - 1);
                end
            end else begin
                m_p[m]  = k;
                m_st[m] = 0;
            end
        end else if (!sticky) begin
            m_st[m] = 0;
        end
    endtask

    task automatic step(input string tag, input bit rs_t, input bit rr, input bit v, input bit d);
        exp_t e;
        reset   = rs_t;
        restart = rr;
        valid   = v;
        data    = d;
        model_step(0, rs_t, rr, v, d);
        model_step(1, rs_t, rr, v, d);
        q_s.push_back('{m_p[0], m_st[0], m_cnt[0]});
        q_p.push_back('{m_p[1], m_st[1], m_cnt[1]});
        @(posedge clk);
        #1;
        e = q_s.pop_front();
        check_val({tag, "/s_prog"},  32'(s_prog),  32'(e.p));
        check_val({tag, "/s_start"}, 32'(s_start), 32'(e.st));
        check_val({tag, "/s_cnt"},   32'(s_cnt),   32'(e.cnt));
        e = q_p.pop_front();
        check_val({tag, "/p_prog"},  32'(p_prog),  32'(e.p));
        check_val({tag, "/p_start"}, 32'(p_start), 32'(e.st));
        check_val({tag, "/p_cnt"},   32'(p_cnt),   32'(e.cnt));
    endtask

    // Feed n valid bits, bits[n-1] first
    task automatic feed(input string tag, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(tag, 1'b0, 1'b0, 1'b1, bits[i]);
        end
    endtask

    int exp_sat [5] = '{1, 2, 3, 3, 3};

    initial begin
        // Reset held for several cycles
        for (int i = 0; i < 3; i++) step("rst_hold", 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("rst_s_start", 32'(s_start), 32'd0);
        check_val("rst_s_cnt",   32'(s_cnt),   32'd0);

        // Basic sticky detection then random data ignored
        feed("basic", 32'b1101, 4);
        check_val("basic_s_cnt",  32'(s_cnt),   32'd1);
        check_val("basic_s_prog", 32'(s_prog),  32'd4);
        check_val("basic_s_st",   32'(s_start), 32'd1);
        check_val("basic_p_prog", 32'(p_prog),  32'd1);
        for (int i = 0; i < 6; i++) begin
            step("basic_rand", 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check_val("hold_s_st",  32'(s_start), 32'd1);
        check_val("hold_s_cnt", 32'(s_cnt),   32'd1);

        // Reset while latched
        step("rst_done", 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("rst_done_s_st",  32'(s_start), 32'd0);
        check_val("rst_done_s_cnt", 32'(s_cnt),   32'd0);

        // Reset mid-sequence discards progress
        feed("mid", 32'b110, 3);
        step("mid_rst", 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("mid_prog0", 32'(s_prog), 32'd0);
        feed("mid_after", 32'b1, 1);
        check_val("mid_prog1", 32'(s_prog),  32'd1);
        check_val("mid_nost",  32'(s_start), 32'd0);

        // Restart (data on that edge ignored) then gapped stream
        step("gap_rr", 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("gap_rr_prog", 32'(s_prog), 32'd0);
        step("gap_b1", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("gap_prog", 32'(s_prog), 32'd1);
        feed("gap_tail", 32'b101, 3);
        check_val("gap_s_st",  32'(s_start), 32'd1);
        check_val("gap_s_cnt", 32'(s_cnt),   32'd1);

        // Restart from latched state, detect again
        step("rearm_rr", 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("rearm_s_st", 32'(s_start), 32'd0);
        feed("rearm", 32'b1101, 4);
        check_val("rearm_s_st",  32'(s_start), 32'd1);
        check_val("rearm_s_cnt", 32'(s_cnt),   32'd2);

        // Overlapping matches in pulse mode
        step("ovl_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        feed("ovl", 32'b1101101, 7);
        check_val("ovl_p_cnt",  32'(p_cnt),   32'd2);
        check_val("ovl_p_prog", 32'(p_prog),  32'd1);
        check_val("ovl_p_st",   32'(p_start), 32'd1);

        // Counter saturation on the 2-bit pulse instance
        step("sat_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 5; r++) begin
            feed("sat", 32'b11010, 5);
            check_val("sat_p_cnt", 32'(p_cnt), 32'(exp_sat[r]));
        end

        // Random traffic with occasional restart and reset
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
